sseg_scan: RTL and testbench
============================

# sseg_scan

Parametrised multiplexed seven-segment display scanner, the successor to the fixed four-digit driver. It supports any digit count, per-digit decimal points and blanking, and PWM brightness. Display data is double-buffered and swapped only at frame boundaries, so the display never tears. It sits between the debug/status logic and the board's segment and anode pins.

## Interface
- `DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `N`, default 16: each digit slot lasts 2**N clocks.
- `BRIGHT_W`, default 4: brightness code width; must be ≤ N.

- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in`  in  4*DIGITS  hex nibbles; nibble d = `in[4d+3:4d]`; digit 0 is rightmost.
- `dp`  in  DIGITS  decimal point request per digit, active high.
- `blank`  in  DIGITS  per-digit blank, active high.
- `bright`  in  BRIGHT_W  brightness code.
- `load`  in  1  request to copy in/dp/blank/bright into the shadow set.
- `c`  out  8  segments, active low; `c[7]` = decimal point.
- `an`  out  DIGITS  anode enables, active low, one-hot-low.
- `frame`  out  1  one-cycle pulse marking the first cycle of each frame.

## Operation
- Prescaler `ctr` is N bits and counts continuously. When it wraps, digit index `dig` advances. From DIGITS-1 it wraps to 0; that event is the frame boundary.
- `load` sets a sticky `pending` flag. At a frame boundary with `pending` set, or with `load` high on that same edge:
  - the shadow registers capture the live in/dp/blank/bright;
  - `pending` clears.
- Otherwise the shadow registers hold their values.
- Glyphs for the shadow nibble of `dig`, bits [6:0] with `c[7]`=1: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:A7 D:A1 E:86 F:8E.
- `c[7]` = ~shadow dp[dig].
- Lit condition: shadow blank[dig]=0 AND `ctr[N-1:N-BRIGHT_W]` < shadow bright.
- When lit: `an[dig]`=0, all other anodes 1, `c` = glyph with dp applied.
- When not lit: `an` all ones, `c`=8'hFF.
- Brightness arithmetic is an unsigned compare. bright=0 keeps the display fully dark. The maximum code gives (2**BRIGHT_W-1)/2**BRIGHT_W duty.
- Reset (asynchronous, at any time, including mid-frame) sets:
  - `ctr`=0, `dig`=0, `pending`=0;
  - shadow in=0, shadow dp=0, shadow blank=all ones, shadow bright=0;
  - `c`=8'hFF, `an`=all ones, `frame`=0.
- The display stays dark until the first load reaches a frame boundary.

## Timing
- `c`, `an` and `frame` are registered. They are computed from the post-edge values of ctr/dig/shadow, so they change on the same edge as `dig`, with no extra lag.
- Slot length is 2**N clocks. Frame length is DIGITS*2**N clocks.
- `frame`=1 for exactly the first cycle of digit 0's slot, whether or not a swap occurred. This is the first cycle that shows new shadow data.
- Load latency: a new value appears at the next frame boundary, at most DIGITS*2**N clocks after `load`.
- Multiple loads within one frame collapse to one capture, and that capture takes the live values at the boundary edge.
- `load` asserted on the boundary edge is captured in that same boundary.
- Live input changes without `load` never affect the outputs.

## Configuration
- `SSEG_LZS_EN`: leading-zero suppression.
- When defined, a digit is treated as blanked if its shadow nibble and every higher shadow nibble are 0. Digit 0 is never suppressed, and a suppressed digit also hides its dp.
- When undefined, all non-blanked digits are shown, including leading zeros.

## Test plan
Bench parameters for all scenarios: DIGITS=4, N=4, BRIGHT_W=2.
- Reset: assert `rst` mid-slot -> immediately `an`=4'b1111, `c`=8'hFF, `frame`=0. After release, `frame` pulses every 64 clocks and the display stays dark.
- Load and swap: in=16'h12AF, bright=3, pulse `load` at clock 5 -> outputs unchanged until the boundary. Then, in slot order: an=1110/c=8E, an=1101/c=88, an=1011/c=A4, an=0111/c=F9. Each digit is lit for 12 of its 16 cycles and dark (an=1111, c=FF) for 4.
- No tearing: change `in` to 16'h0000 mid-frame without `load` -> the display keeps showing 12AF. Pulse `load` -> 0000 is shown from the next `frame` pulse onward.
- Brightness: bright=0 -> always dark. bright=1 -> each digit lit for 4 cycles per slot.
- dp/blank: dp=4'b0010, blank=4'b0100 -> digit 1 shows `c[7]`=0, digit 2 is never lit, and the other digits are unaffected.
- LZS (with `SSEG_LZS_EN`): in=16'h0050 -> digits 3 and 2 dark, digits 1 and 0 show 92 and C0. in=0 -> only digit 0 is lit, showing C0. Without the macro: all four digits are lit.

Source files
------------

// File: rtl/sseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan
// Description : Multiplexed seven-segment scanner for any digit count.
//               Supports per-digit decimal point and blanking, and PWM
//               brightness. Display data is double-buffered and swapped only
//               at frame boundaries, so the display never tears.
//               Optional macro SSEG_LZS_EN enables leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan #(
    parameter int DIGITS   = 4,
    parameter int N        = 16,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  load,
    output logic [7:0]            c,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int              DW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0]   c_LAST_DIG = DW'(DIGITS - 1);
    localparam logic [N-1:0]    c_CTR_MAX  = {N{1'b1}};

    // Scan state
    logic [N-1:0]           r_ctr;
    logic [DW-1:0]          r_dig;
    logic                   r_pending;

    // Shadow (displayed) data set
    logic [4*DIGITS-1:0]    r_sh_in;
    logic [DIGITS-1:0]      r_sh_dp;
    logic [DIGITS-1:0]      r_sh_blank;
    logic [BRIGHT_W-1:0]    r_sh_bright;

    // Registered pin drivers
    logic [7:0]             r_c;
    logic [DIGITS-1:0]      r_an;
    logic                   r_frame;

    // Post-edge values; outputs are derived from these so they move on the
    // same edge as the digit index.
    logic                   w_wrap;
    logic                   w_last;
    logic                   w_bound;
    logic                   w_swap;
    logic [N-1:0]           w_ctr_nx;
    logic [DW-1:0]          w_dig_nx;
    logic [4*DIGITS-1:0]    w_sh_in_nx;
    logic [DIGITS-1:0]      w_sh_dp_nx;
    logic [DIGITS-1:0]      w_sh_blank_nx;
    logic [BRIGHT_W-1:0]    w_sh_bright_nx;

    logic [3:0]             w_nib;
    logic                   w_dp_sel;
    logic                   w_blank_sel;
    logic                   w_lz_sel;
    logic [DIGITS-1:0]      w_lz;
    logic                   w_lit;
    logic [7:0]             w_c_nx;
    logic [DIGITS-1:0]      w_an_nx;

    // Segment pattern (bits 6:0, active low) for a hex nibble
    function automatic logic [6:0] f_glyph(input logic [3:0] i_nib);
        logic [6:0] v_g;
        case (i_nib)
            4'h0: v_g = 7'h40;
            4'h1: v_g = 7'h79;
            4'h2: v_g = 7'h24;
            4'h3: v_g = 7'h30;
            4'h4: v_g = 7'h19;
            4'h5: v_g = 7'h12;
            4'h6: v_g = 7'h02;
            4'h7: v_g = 7'h78;
            4'h8: v_g = 7'h00;
            4'h9: v_g = 7'h10;
            4'hA: v_g = 7'h08;
            4'hB: v_g = 7'h03;
            4'hC: v_g = 7'h27;
            4'hD: v_g = 7'h21;
            4'hE: v_g = 7'h06;
            default: v_g = 7'h0E;
        endcase
        return v_g;
    endfunction

    // Prescaler/digit advance and the frame-boundary swap decision
    always_comb begin
        w_wrap   = (r_ctr == c_CTR_MAX);
        w_last   = (r_dig == c_LAST_DIG);
        w_bound  = w_wrap & w_last;
        w_swap   = w_bound & (r_pending | load);
        w_ctr_nx = r_ctr + 1'b1;
        if (!w_wrap)
            w_dig_nx = r_dig;
        else if (w_last)
            w_dig_nx = '0;
        else
            w_dig_nx = r_dig + 1'b1;
        w_sh_in_nx     = w_swap ? in     : r_sh_in;
        w_sh_dp_nx     = w_swap ? dp     : r_sh_dp;
        w_sh_blank_nx  = w_swap ? blank  : r_sh_blank;
        w_sh_bright_nx = w_swap ? bright : r_sh_bright;
    end

`ifdef SSEG_LZS_EN
    // A digit is suppressed when it and every higher shadow nibble are zero;
    // digit 0 is always shown.
    always_comb begin
        logic v_zero_run;
        v_zero_run = 1'b1;
        w_lz       = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            v_zero_run = v_zero_run & (w_sh_in_nx[4*d +: 4] == 4'h0);
            w_lz[d]    = v_zero_run & (d != 0);
        end
    end
`else
    assign w_lz = '0;
`endif

    // Select the shadow data belonging to the digit shown after this edge
    always_comb begin
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b1;
        w_lz_sel    = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_dig_nx == DW'(d)) begin
                w_nib       = w_sh_in_nx[4*d +: 4];
                w_dp_sel    = w_sh_dp_nx[d];
                w_blank_sel = w_sh_blank_nx[d];
                w_lz_sel    = w_lz[d];
            end
        end
    end

    // PWM gating and pin patterns; brightness compares the top counter bits
    always_comb begin
        w_lit  = ~w_blank_sel & ~w_lz_sel &
                 (w_ctr_nx[N-1 -: BRIGHT_W] < w_sh_bright_nx);
        w_c_nx = w_lit ? {~w_dp_sel, f_glyph(w_nib)} : 8'hFF;
        for (int d = 0; d < DIGITS; d++)
            w_an_nx[d] = ~(w_lit & (w_dig_nx == DW'(d)));
    end

    // State, shadow set and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr       <= '0;
            r_dig       <= '0;
            r_pending   <= 1'b0;
            r_sh_in     <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '1;
            r_sh_bright <= '0;
            r_c         <= 8'hFF;
            r_an        <= '1;
            r_frame     <= 1'b0;
        end else begin
            r_ctr       <= w_ctr_nx;
            r_dig       <= w_dig_nx;
            if (w_swap)
                r_pending <= 1'b0;
            else if (load)
                r_pending <= 1'b1;
            r_sh_in     <= w_sh_in_nx;
            r_sh_dp     <= w_sh_dp_nx;
            r_sh_blank  <= w_sh_blank_nx;
            r_sh_bright <= w_sh_bright_nx;
            r_c         <= w_c_nx;
            r_an        <= w_an_nx;
            r_frame     <= w_bound;
        end
    end

    assign c     = r_c;
    assign an    = r_an;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan
// Description : Self-checking bench for sseg_scan (DIGITS=4, N=4, BRIGHT_W=2).
//               A reference model derives the expected pins from the absolute
//               cycle count since reset and queues them; a monitor pops and
//               compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan;

    localparam int DIGITS   = 4;
    localparam int N        = 4;
    localparam int BRIGHT_W = 2;
    localparam int SLOT     = 16;
    localparam int FRAME    = 64;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic [15:0] in_v   = 16'h0;
    logic [3:0]  dp_v   = 4'h0;
    logic [3:0]  bl_v   = 4'h0;
    logic [1:0]  br_v   = 2'd0;
    logic        load_v = 1'b0;
    logic [7:0]  c_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [12:0] exp_q[$];

    // Reference model state
    int          k      = 0;
    logic [15:0] sh_in  = 16'h0;
    logic [3:0]  sh_dp  = 4'h0;
    logic [3:0]  sh_bl  = 4'hF;
    logic [1:0]  sh_br  = 2'd0;
    bit          pend   = 1'b0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

    sseg_scan #(.DIGITS(DIGITS), .N(N), .BRIGHT_W(BRIGHT_W)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_v),
        .dp     (dp_v),
        .blank  (bl_v),
        .bright (br_v),
        .load   (load_v),
        .c      (c_o),
        .an     (an_o),
        .frame  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got frame=%b an=%b c=%h, required frame=%b an=%b c=%h",
                     name, $time, act[12], act[11:8], act[7:0], exp[12], exp[11:8], exp[7:0]);
        end
    endtask

    // Expected pins kk edges after reset release, from slot/frame arithmetic
    function automatic logic [12:0] expect_at(input int kk, input logic [15:0] s_in,
                                              input logic [3:0] s_dp, input logic [3:0] s_bl,
                                              input logic [1:0] s_br);
        int         pos = kk % SLOT;
        int         d   = (kk / SLOT) % DIGITS;
        bit         lit;
        bit         fr;
        logic [3:0] nib;
        logic [7:0] g;
        logic [3:0] an_e;
        logic [7:0] c_e;
        nib = s_in[4*d +: 4];
        g   = glyph[nib];
        lit = !s_bl[d] && ((pos / 4) < int'(s_br));
`ifdef SSEG_LZS_EN
        if (d != 0 && (s_in >> (4*d)) == 16'h0)
            lit = 1'b0;
`endif
        fr   = (kk > 0) && (kk % FRAME == 0);
        an_e = lit ? ~(4'b0001 << d) : 4'hF;
        c_e  = lit ? {~s_dp[d], g[6:0]} : 8'hFF;
        return {fr, an_e, c_e};
    endfunction

    // Reference model: tracks the displayed data set and queues expectations
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                k     = 0;
                sh_in = 16'h0;
                sh_dp = 4'h0;
                sh_bl = 4'hF;
                sh_br = 2'd0;
                pend  = 1'b0;
                exp_q.delete();
                exp_q.push_back({1'b0, 4'hF, 8'hFF});
            end else begin
                k++;
                if ((k % FRAME == 0) && (pend || load_v)) begin
                    sh_in = in_v;
                    sh_dp = dp_v;
                    sh_bl = bl_v;
                    sh_br = br_v;
                    pend  = 1'b0;
                end else if (load_v) begin
                    pend = 1'b1;
                end
                exp_q.push_back(expect_at(k, sh_in, sh_dp, sh_bl, sh_br));
            end
        end
    end

    // Monitor: compare DUT pins against the queued expectation each cycle
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty @%0t: got no expectation, required one per cycle", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("scan", {frame_o, an_o, c_o}, e);
                end
            end
        end
    end

    task automatic pulse_load();
        load_v = 1'b1;
        @(negedge clk);
        load_v = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        int guard;
        #2 rst = 1'b1;
        #1 mon_en = 1'b1;
        wait_cycles(3);
        rst = 1'b0;

        // Dark after reset, frame pulses every 64 clocks
        wait_cycles(140);

        // Load and swap: 12AF at full-scale brightness
        in_v = 16'h12AF;
        br_v = 2'd3;
        wait_cycles(5);
        pulse_load();
        wait_cycles(140);

        // No tearing: live change without load, then load
        in_v = 16'h0000;
        wait_cycles(70);
        pulse_load();
        wait_cycles(80);

        // Asynchronous reset mid-slot while the display is lit
        in_v = 16'h12AF;
        pulse_load();
        wait_cycles(90);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset", {frame_o, an_o, c_o}, {1'b0, 4'hF, 8'hFF});
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(140);

        // Brightness 0 and 1
        br_v = 2'd0;
        pulse_load();
        wait_cycles(140);
        br_v = 2'd1;
        pulse_load();
        wait_cycles(140);

        // Decimal point and blank
        dp_v = 4'b0010;
        bl_v = 4'b0100;
        br_v = 2'd3;
        in_v = 16'($urandom);
        pulse_load();
        wait_cycles(140);

        // Load asserted on the boundary edge itself
        guard = 0;
        while ((k % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if ((k % FRAME) != FRAME - 1) begin
            n_fail++;
            $display("FAIL boundary_align: got phase %0d, required %0d", k % FRAME, FRAME - 1);
        end
        in_v = 16'h5A3C;
        dp_v = 4'b1001;
        bl_v = 4'b0000;
        pulse_load();
        wait_cycles(70);

        // Randomized traffic: multiple loads per frame, live changes
        for (int i = 0; i < 25; i++) begin
            in_v   = 16'($urandom);
            dp_v   = 4'($urandom);
            bl_v   = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            br_v   = 2'($urandom);
            load_v = 1'($urandom);
            @(negedge clk);
            load_v = 1'b0;
            wait_cycles($urandom_range(1, 90));
        end

        // Leading zeros
        dp_v = 4'b0000;
        bl_v = 4'b0000;
        br_v = 2'd3;
        in_v = 16'h0050;
        pulse_load();
        wait_cycles(140);
        in_v = 16'h0000;
        pulse_load();
        wait_cycles(140);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
